// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side byte buffer placed between the UART receiver and the
// instrument-bus logic. Bytes arrive over a valid/ack handshake and go into a
// first-word-fall-through FIFO. Line terminators held in the FIFO are counted
// so the command parser can wait for a complete line before it reads.
//
// When the FIFO is full the ack is withheld. That stalls the receiver, which
// keeps RTS deasserted and so applies hardware flow control. No byte is ever
// dropped because of a full FIFO.
//
// Parameters
//   DEPTH  number of FIFO entries (power of two, >= 2)
//   TERM   byte value counted as a line terminator
//
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset, sampled on rising clk
//   in_data     byte from the receiver
//   in_valid    receiver byte valid; held until acked and may linger one
//               cycle after the ack is seen
//   in_ack_n    registered active-low ack to the receiver
//   flush       synchronous FIFO clear
//   rd_en       pop the head entry
//   rd_data     head entry (FWFT); 8'h00 while empty
//   empty       level == 0
//   full        level == DEPTH
//   level       number of entries stored
//   line_count  number of TERM bytes stored
//   line_avail  line_count != 0
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int          DEPTH = 16,
    parameter logic [7:0]  TERM  = 8'h0A
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ack_n,
    input  logic                       flush,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     line_count,
    output logic                       line_avail
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t          r_state;
    logic            r_ack_n;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [LW-1:0]   r_line_count;

    // ---------------------------------------------------------------------
    // Decoded status and the write/pop qualifiers
    // ---------------------------------------------------------------------
    logic            w_empty;
    logic            w_full;
    logic            w_wr_en;
    logic            w_rd_en;
    logic            w_wr_term;
    logic            w_rd_term;
    logic [7:0]      w_head;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_head  = r_mem[r_rd_ptr];

    // A byte is taken only on the IDLE->ACK transition. The full check uses
    // the level before any pop in the same cycle, so a full FIFO accepts the
    // byte one cycle after space is freed.
    assign w_wr_en = (r_state == ST_IDLE) && in_valid && !w_full;
    // A pop on an empty FIFO is ignored.
    assign w_rd_en = rd_en && !w_empty;

    assign w_wr_term = w_wr_en && (in_data == TERM);
    assign w_rd_term = w_rd_en && (w_head == TERM);

    // ---------------------------------------------------------------------
    // Input handshake FSM. The ack is registered, so there is no
    // combinational path from in_valid to in_ack_n. The ACK state ignores
    // the lingering in_valid, which gives exactly one write per byte.
    // flush does not touch the handshake.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <=, so every flop
        // samples the values from before the edge.
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ack_n <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && !w_full) begin
                        r_state <= ST_ACK;
                        r_ack_n <= 1'b0;
                    end
                end
                ST_ACK: begin
                    if (!in_valid) begin
                        r_state <= ST_IDLE;
                        r_ack_n <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ack_n <= 1'b1;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Storage array
    // ---------------------------------------------------------------------
    // NOTE: the array has no reset. Empty/level gate every read, so stale
    // contents are never visible, and a reset-free array maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // ---------------------------------------------------------------------
    // Pointers, level and terminator count. flush takes priority over any
    // write or pop in the same cycle. The pointers wrap naturally because
    // DEPTH is a power of two.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_line_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            case ({w_wr_term, w_rd_term})
                2'b10:   r_line_count <= r_line_count + LW'(1);
                2'b01:   r_line_count <= r_line_count - LW'(1);
                default: r_line_count <= r_line_count;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs, all registered or decoded from registered state
    // ---------------------------------------------------------------------
    assign in_ack_n   = r_ack_n;
    assign rd_data    = w_empty ? 8'h00 : w_head;
    assign empty      = w_empty;
    assign full       = w_full;
    assign level      = r_level;
    assign line_count = r_line_count;
    assign line_avail = (r_line_count != '0);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed bench for uart_rx_fifo with DEPTH=16 and TERM=8'h0A. The bench
// drives inputs and samples outputs 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ack_n;
    logic       flush;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic [4:0] line_count;
    logic       line_avail;

    int checks;
    int failures;

    uart_rx_fifo #(
        .DEPTH (16),
        .TERM  (8'h0A)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ack_n   (in_ack_n),
        .flush      (flush),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .line_count (line_count),
        .line_avail (line_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver-style byte transfer: hold valid until the ack is seen, keep
    // valid high one more cycle, then drop it and let the FSM return to IDLE.
    task automatic send_byte(input logic [7:0] b);
        bit acked;
        acked    = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (in_ack_n === 1'b0) begin
                acked = 1'b1;
                break;
            end
        end
        checks++;
        if (!acked) begin
            failures++;
            $display("FAIL send_ack_timeout byte=%02h in_ack_n=%b expected=0", b, in_ack_n);
        end
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        rd_en    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ack_n !== 1'b1) begin failures++; $display("FAIL reset_ack got=%b exp=1", in_ack_n); end
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (line_count !== 5'd0) begin failures++; $display("FAIL reset_line_count got=%0d exp=0", line_count); end
        checks++; if (line_avail !== 1'b0) begin failures++; $display("FAIL reset_line_avail got=%b exp=0", line_avail); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%02h exp=00", rd_data); end
    endtask

    task automatic test_single_byte();
        in_data  = 8'h41;
        in_valid = 1'b1;
        tick();
        checks++; if (in_ack_n !== 1'b0) begin failures++; $display("FAIL single_ack got=%b exp=0", in_ack_n); end
        checks++; if (level !== 5'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
        checks++; if (rd_data !== 8'h41) begin failures++; $display("FAIL single_rd_data got=%02h exp=41", rd_data); end
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", empty); end
        // valid lingers one cycle after the ack: no second write
        tick();
        checks++; if (level !== 5'd1) begin failures++; $display("FAIL single_linger_level got=%0d exp=1", level); end
        in_valid = 1'b0;
        tick();
        checks++; if (in_ack_n !== 1'b1) begin failures++; $display("FAIL single_ack_release got=%b exp=1", in_ack_n); end
    endtask

    task automatic test_full();
        logic [7:0] exp_seq [16];
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", full); end
        checks++; if (level !== 5'd16) begin failures++; $display("FAIL full_level got=%0d exp=16", level); end

        // 17th byte is stalled while the FIFO is full
        in_data  = 8'h55;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (in_ack_n !== 1'b1) begin failures++; $display("FAIL full_stall_ack cyc=%0d got=%b exp=1", i, in_ack_n); end
        end
        checks++; if (level !== 5'd16) begin failures++; $display("FAIL full_stall_level got=%0d exp=16", level); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL full_head got=%02h exp=00", rd_data); end

        // one pop: no write in the same cycle because full is sampled before it
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (in_ack_n !== 1'b1) begin failures++; $display("FAIL full_pop_ack got=%b exp=1", in_ack_n); end
        checks++; if (level !== 5'd15) begin failures++; $display("FAIL full_pop_level got=%0d exp=15", level); end
        tick();
        checks++; if (in_ack_n !== 1'b0) begin failures++; $display("FAIL full_accept_ack got=%b exp=0", in_ack_n); end
        checks++; if (level !== 5'd16) begin failures++; $display("FAIL full_accept_level got=%0d exp=16", level); end
        tick();
        in_valid = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) exp_seq[i] = 8'(i + 1);
        exp_seq[15] = 8'h55;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rd_data !== exp_seq[i]) begin
                failures++;
                $display("FAIL full_drain idx=%0d got=%02h exp=%02h", i, rd_data, exp_seq[i]);
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drain_empty got=%b exp=1", empty); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL full_drain_rd_data got=%02h exp=00", rd_data); end
    endtask

    task automatic test_lines();
        do_reset();
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h0A);
        send_byte(8'h43);
        checks++; if (line_count !== 5'd1) begin failures++; $display("FAIL lines_count got=%0d exp=1", line_count); end
        checks++; if (line_avail !== 1'b1) begin failures++; $display("FAIL lines_avail got=%b exp=1", line_avail); end
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        checks++; if (line_count !== 5'd0) begin failures++; $display("FAIL lines_count_after got=%0d exp=0", line_count); end
        checks++; if (line_avail !== 1'b0) begin failures++; $display("FAIL lines_avail_after got=%b exp=0", line_avail); end
        checks++; if (rd_data !== 8'h43) begin failures++; $display("FAIL lines_rd_data got=%02h exp=43", rd_data); end
        checks++; if (level !== 5'd1) begin failures++; $display("FAIL lines_level got=%0d exp=1", level); end
    endtask

    // Continues from test_lines: FIFO holds 8'h43.
    task automatic test_back_to_back();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        send_byte(8'h0A);
        checks++; if (line_count !== 5'd1) begin failures++; $display("FAIL b2b_pre_count got=%0d exp=1", line_count); end
        checks++; if (rd_data !== 8'h0A) begin failures++; $display("FAIL b2b_pre_head got=%02h exp=0a", rd_data); end
        // pop the 0A head while writing a new 0A in the same cycle
        in_data  = 8'h0A;
        in_valid = 1'b1;
        rd_en    = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (line_count !== 5'd1) begin failures++; $display("FAIL b2b_line_count got=%0d exp=1", line_count); end
        checks++; if (level !== 5'd1) begin failures++; $display("FAIL b2b_level got=%0d exp=1", level); end
        checks++; if (in_ack_n !== 1'b0) begin failures++; $display("FAIL b2b_ack got=%b exp=0", in_ack_n); end
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        logic [7:0] bytes [5];
        bytes[0] = 8'h10; bytes[1] = 8'h0A; bytes[2] = 8'h20; bytes[3] = 8'h0A; bytes[4] = 8'h30;
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(bytes[i]);
        checks++; if (level !== 5'd5) begin failures++; $display("FAIL flush_pre_level got=%0d exp=5", level); end
        checks++; if (line_count !== 5'd2) begin failures++; $display("FAIL flush_pre_count got=%0d exp=2", line_count); end
        flush = 1'b1;
        rd_en = 1'b1;
        tick();
        flush = 1'b0;
        rd_en = 1'b0;
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", empty); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL flush_rd_data got=%02h exp=00", rd_data); end
        checks++; if (line_count !== 5'd0) begin failures++; $display("FAIL flush_line_count got=%0d exp=0", line_count); end
        // pop on empty is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL underflow_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL underflow_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL underflow_full got=%b exp=0", full); end
        // pointers unchanged: the next byte lands at the head
        send_byte(8'h66);
        checks++; if (rd_data !== 8'h66) begin failures++; $display("FAIL underflow_next got=%02h exp=66", rd_data); end
        checks++; if (level !== 5'd1) begin failures++; $display("FAIL underflow_next_level got=%0d exp=1", level); end
    endtask

    task automatic test_reset_in_ack();
        do_reset();
        in_data  = 8'h77;
        in_valid = 1'b1;
        tick();
        checks++; if (in_ack_n !== 1'b0) begin failures++; $display("FAIL rst_ack_enter got=%b exp=0", in_ack_n); end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++; if (in_ack_n !== 1'b1) begin failures++; $display("FAIL rst_ack_release got=%b exp=1", in_ack_n); end
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL rst_ack_level got=%0d exp=0", level); end
        rst_n = 1'b1;
        tick();
        // FSM is in IDLE: a new byte is accepted on the next edge
        in_data  = 8'h99;
        in_valid = 1'b1;
        tick();
        checks++; if (in_ack_n !== 1'b0) begin failures++; $display("FAIL rst_idle_ack got=%b exp=0", in_ack_n); end
        checks++; if (rd_data !== 8'h99) begin failures++; $display("FAIL rst_idle_data got=%02h exp=99", rd_data); end
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        flush    = 1'b0;
        rd_en    = 1'b0;

        test_reset();
        test_single_byte();
        test_full();
        test_lines();
        test_back_to_back();
        test_flush();
        test_reset_in_ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
